// File: rtl/arb_pkg.sv
// Shared constants and types for the four-way packet-locking round-robin arbiter.
// The control state is kept in one struct so the whole FSM is visible as a single signal.
package arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_e;

   typedef struct packed {
      arb_state_e       state;
      logic [IDX_W-1:0] rr;
      logic [IDX_W-1:0] lock_id;
   } arb_ctl_t;

   // rr=3 so requester 0 is scanned first after reset
   localparam arb_ctl_t CTL_RST = '{state: ST_IDLE, rr: 2'd3, lock_id: 2'd0};

   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Rotating-priority picker: scans i_ptr+1, i_ptr+2, i_ptr+3, i_ptr (mod 4) and
// returns the first asserted request as a one-hot grant and an index.
module rr_pick_4
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      cand  = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int k = 1; k <= int'(N_REQ); k++) begin
         cand = i_ptr + IDX_W'(k);
         if (!o_any && i_req[cand]) begin
            o_any = 1'b1;
            o_idx = cand;
         end
      end
      o_gnt = idx_to_onehot(o_idx) & {N_REQ{o_any}};
   end

endmodule

// File: rtl/arb_out_4_rr_pkt.sv
// Four-requester round-robin arbiter that keeps the output channel locked to one
// requester until its last beat is taken, feeding a one-entry registered output stage.
module arb_out_4_rr_pkt
   import arb_pkg::*;
#(
   parameter int p_width = 8
) (
   input  logic               i_clk,
   input  logic               i_nrst,
   input  logic               i_req0,
   input  logic               i_req1,
   input  logic               i_req2,
   input  logic               i_req3,
   input  logic [p_width-1:0] i_data0,
   input  logic [p_width-1:0] i_data1,
   input  logic [p_width-1:0] i_data2,
   input  logic [p_width-1:0] i_data3,
   input  logic               i_last0,
   input  logic               i_last1,
   input  logic               i_last2,
   input  logic               i_last3,
   output logic               o_acc0,
   output logic               o_acc1,
   output logic               o_acc2,
   output logic               o_acc3,
   output logic               o_req,
   output logic [p_width-1:0] o_data,
   output logic               o_last,
   output logic [IDX_W-1:0]   o_owner,
   input  logic               i_acc
);

   // Valid/ready contract on both sides: a beat moves only in a cycle where the
   // sender's valid (i_reqN / o_req) and the receiver's accept (o_accN / i_acc)
   // are both high; the sender holds its beat stable until then.

   logic [N_REQ-1:0]   req_v;
   logic [N_REQ-1:0]   last_v;
   logic [p_width-1:0] data_a [N_REQ];
   logic [N_REQ-1:0]   elig;
   logic [N_REQ-1:0]   gnt;
   logic [IDX_W-1:0]   win_idx;
   logic               win_any;
   logic               ld;
   logic               take;
   logic [N_REQ-1:0]   acc_v;

   arb_ctl_t           ctl_q, ctl_d;
   logic               o_req_q, o_req_d;
   logic [p_width-1:0] o_data_q, o_data_d;
   logic               o_last_q, o_last_d;
   logic [IDX_W-1:0]   o_owner_q, o_owner_d;

   assign req_v     = {i_req3, i_req2, i_req1, i_req0};
   assign last_v    = {i_last3, i_last2, i_last1, i_last0};
   assign data_a[0] = i_data0;
   assign data_a[1] = i_data1;
   assign data_a[2] = i_data2;
   assign data_a[3] = i_data3;

   // While locked only the owner is visible to the picker, so rr cannot drift
   always_comb begin
      elig = req_v;
      if (ctl_q.state == ST_LOCK) begin
         elig = req_v & idx_to_onehot(ctl_q.lock_id);
      end
   end

   rr_pick_4 u_pick (
      .i_req (elig),
      .i_ptr (ctl_q.rr),
      .o_gnt (gnt),
      .o_idx (win_idx),
      .o_any (win_any)
   );

   assign ld    = ~o_req_q | i_acc;
   assign take  = ld & win_any & i_nrst;
   assign acc_v = gnt & {N_REQ{take}};

   assign o_acc0 = acc_v[0];
   assign o_acc1 = acc_v[1];
   assign o_acc2 = acc_v[2];
   assign o_acc3 = acc_v[3];

   always_comb begin
      ctl_d     = ctl_q;
      o_req_d   = o_req_q;
      o_data_d  = o_data_q;
      o_last_d  = o_last_q;
      o_owner_d = o_owner_q;

      if (take) begin
         o_req_d   = 1'b1;
         o_data_d  = data_a[win_idx];
         o_last_d  = last_v[win_idx];
         o_owner_d = win_idx;
         if (last_v[win_idx]) begin
            ctl_d.state = ST_IDLE;
            ctl_d.rr    = win_idx;
         end else begin
            ctl_d.state   = ST_LOCK;
            ctl_d.lock_id = win_idx;
         end
      end else if (i_acc) begin
         o_req_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         ctl_q     <= CTL_RST;
         o_req_q   <= 1'b0;
         o_data_q  <= '0;
         o_last_q  <= 1'b0;
         o_owner_q <= '0;
      end else begin
         ctl_q     <= ctl_d;
         o_req_q   <= o_req_d;
         o_data_q  <= o_data_d;
         o_last_q  <= o_last_d;
         o_owner_q <= o_owner_d;
      end
   end

   assign o_req   = o_req_q;
   assign o_data  = o_data_q;
   assign o_last  = o_last_q;
   assign o_owner = o_owner_q;

endmodule

// File: tb/tb_arb_out_4_rr_pkt.sv
// Bench for arb_out_4_rr_pkt: queue-based reference model compared every cycle,
// directed packet scenarios with literal expectations, and a standalone picker sweep.
module tb_arb_out_4_rr_pkt;

   localparam int W    = 8;
   localparam int SB_W = 2 + 1 + W;

   logic         clk;
   logic         nrst;
   logic [3:0]   req;
   logic [3:0]   last;
   logic [W-1:0] data [4];
   logic         acc;

   logic         o_acc0, o_acc1, o_acc2, o_acc3;
   logic         o_req;
   logic [W-1:0] o_data;
   logic         o_last;
   logic [1:0]   o_owner;
   logic [3:0]   acc_v;

   logic [3:0]   pk_req;
   logic [1:0]   pk_ptr;
   logic [3:0]   pk_gnt;
   logic [1:0]   pk_idx;
   logic         pk_any;

   int n_chk  = 0;
   int n_pass = 0;

   assign acc_v = {o_acc3, o_acc2, o_acc1, o_acc0};

   arb_out_4_rr_pkt #(.p_width(W)) dut (
      .i_clk   (clk),
      .i_nrst  (nrst),
      .i_req0  (req[0]),
      .i_req1  (req[1]),
      .i_req2  (req[2]),
      .i_req3  (req[3]),
      .i_data0 (data[0]),
      .i_data1 (data[1]),
      .i_data2 (data[2]),
      .i_data3 (data[3]),
      .i_last0 (last[0]),
      .i_last1 (last[1]),
      .i_last2 (last[2]),
      .i_last3 (last[3]),
      .o_acc0  (o_acc0),
      .o_acc1  (o_acc1),
      .o_acc2  (o_acc2),
      .o_acc3  (o_acc3),
      .o_req   (o_req),
      .o_data  (o_data),
      .o_last  (o_last),
      .o_owner (o_owner),
      .i_acc   (acc)
   );

   rr_pick_4 u_pick_tb (
      .i_req (pk_req),
      .i_ptr (pk_ptr),
      .o_gnt (pk_gnt),
      .o_idx (pk_idx),
      .o_any (pk_any)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // reference model: pointer, lock owner and an output queue of depth one
   int  m_rr   = 3;
   bit  m_lock = 1'b0;
   int  m_lid  = 0;
   bit  m_full = 1'b0;
   int  m_gnt;
   logic [SB_W-1:0] exp_q [$];

   always_comb begin
      m_gnt = -1;
      if (nrst && (!m_full || acc)) begin
         if (m_lock) begin
            if (req[m_lid]) m_gnt = m_lid;
         end else begin
            for (int k = 4; k >= 1; k--) begin
               if (req[(m_rr + k) % 4]) m_gnt = (m_rr + k) % 4;
            end
         end
      end
   end

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         m_rr   <= 3;
         m_lock <= 1'b0;
         m_lid  <= 0;
         m_full <= 1'b0;
         exp_q.delete();
      end else begin
         if (m_full && acc) begin
            void'(exp_q.pop_front());
            m_full <= 1'b0;
         end
         if (m_gnt >= 0) begin
            exp_q.push_back({2'(m_gnt), last[m_gnt], data[m_gnt]});
            m_full <= 1'b1;
            if (last[m_gnt]) begin
               m_rr   <= m_gnt;
               m_lock <= 1'b0;
            end else begin
               m_lock <= 1'b1;
               m_lid  <= m_gnt;
            end
         end
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      if (!nrst) begin
         chk("rst_acc", 32'(acc_v), 32'd0);
         chk("rst_oreq", 32'(o_req), 32'd0);
      end else begin
         chk("m_acc", 32'(acc_v), (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
         chk("m_oreq", 32'(o_req), 32'(m_full));
         if (m_full && exp_q.size() != 0)
            chk("m_obeat", 32'({o_owner, o_last, o_data}), 32'(exp_q[0]));
      end
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic set_r(input int n, input logic v, input logic [W-1:0] d, input logic l);
      req[n]  = v;
      data[n] = d;
      last[n] = l;
   endtask

   task automatic clr_all();
      for (int n = 0; n < 4; n++) set_r(n, 1'b0, '0, 1'b0);
   endtask

   task automatic reset_dut();
      nrst = 1'b0;
      clr_all();
      acc = 1'b0;
      @(negedge clk);
      #1 nrst = 1'b1;
      cyc();
   endtask

   initial begin
      int e;
      nrst = 1'b1;
      acc  = 1'b0;
      clr_all();
      pk_req = '0;
      pk_ptr = '0;
      #1 nrst = 1'b0;

      // standalone picker sweep
      for (int r = 0; r < 16; r++) begin
         for (int p = 0; p < 4; p++) begin
            pk_req = 4'(r);
            pk_ptr = 2'(p);
            #1;
            e = -1;
            for (int k = 1; k <= 4; k++) begin
               if (e < 0 && r[(p + k) % 4]) e = (p + k) % 4;
            end
            chk("pick_gnt", 32'(pk_gnt), (e < 0) ? 32'd0 : (32'd1 << e));
            chk("pick_any", 32'(pk_any), (e < 0) ? 32'd0 : 32'd1);
            if (e >= 0) chk("pick_idx", 32'(pk_idx), 32'(e));
         end
      end

      // 1: reset values, single beat, latency, rr moves to 0
      set_r(0, 1'b1, 8'h11, 1'b1);
      acc = 1'b1;
      #1;
      chk("t1_rst_acc", 32'(acc_v), 32'd0);
      chk("t1_rst_oreq", 32'(o_req), 32'd0);
      chk("t1_rst_odata", 32'(o_data), 32'd0);
      chk("t1_rst_owner", 32'(o_owner), 32'd0);
      chk("t1_rst_olast", 32'(o_last), 32'd0);
      @(negedge clk);
      #1 nrst = 1'b1;
      #1 chk("t1_acc0", 32'(acc_v), 32'b0001);
      cyc();
      set_r(0, 1'b0, '0, 1'b0);
      mid();
      chk("t1_oreq", 32'(o_req), 32'd1);
      chk("t1_odata", 32'(o_data), 32'h11);
      chk("t1_owner", 32'(o_owner), 32'd0);
      chk("t1_idle_acc", 32'(acc_v), 32'd0);
      cyc();
      set_r(0, 1'b1, 8'h12, 1'b1);
      set_r(1, 1'b1, 8'h13, 1'b1);
      mid();
      chk("t1_rr_is0", 32'(acc_v), 32'b0010);
      chk("t1_drained", 32'(o_req), 32'd0);
      cyc();

      // 2: all four single-beat requesters, full throughput
      reset_dut();
      acc = 1'b1;
      for (int n = 0; n < 4; n++) set_r(n, 1'b1, 8'(8'h20 + n), 1'b1);
      for (int i = 0; i < 8; i++) begin
         mid();
         chk("t2_gnt", 32'(acc_v), 32'd1 << (i % 4));
         if (i > 0) begin
            chk("t2_oreq", 32'(o_req), 32'd1);
            chk("t2_owner", 32'(o_owner), 32'((i - 1) % 4));
            chk("t2_odata", 32'(o_data), 32'(8'h20 + (i - 1) % 4));
         end
         cyc();
      end

      // 3: three-beat packet from 1 holds off 2 even though rr favours 2
      reset_dut();
      acc = 1'b1;
      set_r(1, 1'b1, 8'h30, 1'b1);
      mid();
      chk("t3_pre", 32'(acc_v), 32'b0010);
      cyc();
      set_r(1, 1'b1, 8'h31, 1'b0);
      mid();
      chk("t3_b1", 32'(acc_v), 32'b0010);
      cyc();
      set_r(1, 1'b1, 8'h32, 1'b0);
      set_r(2, 1'b1, 8'h40, 1'b1);
      mid();
      chk("t3_b2", 32'(acc_v), 32'b0010);
      cyc();
      set_r(1, 1'b1, 8'h33, 1'b1);
      mid();
      chk("t3_b3", 32'(acc_v), 32'b0010);
      chk("t3_b2_data", 32'(o_data), 32'h32);
      chk("t3_b2_last", 32'(o_last), 32'd0);
      cyc();
      set_r(1, 1'b0, '0, 1'b0);
      mid();
      chk("t3_req2_wins", 32'(acc_v), 32'b0100);
      chk("t3_b3_data", 32'(o_data), 32'h33);
      chk("t3_b3_last", 32'(o_last), 32'd1);
      cyc();
      set_r(2, 1'b0, '0, 1'b0);
      mid();
      chk("t3_r2_data", 32'(o_data), 32'h40);
      chk("t3_r2_owner", 32'(o_owner), 32'd2);
      cyc();

      // 4: backpressure holds the output and stalls requester 3
      reset_dut();
      acc = 1'b0;
      set_r(0, 1'b1, 8'h50, 1'b1);
      mid();
      chk("t4_first", 32'(acc_v), 32'b0001);
      cyc();
      set_r(0, 1'b0, '0, 1'b0);
      set_r(3, 1'b1, 8'h53, 1'b1);
      for (int i = 0; i < 4; i++) begin
         mid();
         chk("t4_hold_acc", 32'(acc_v), 32'd0);
         chk("t4_hold_data", 32'(o_data), 32'h50);
         chk("t4_hold_oreq", 32'(o_req), 32'd1);
         cyc();
      end
      acc = 1'b1;
      mid();
      chk("t4_release", 32'(acc_v), 32'b1000);
      cyc();
      set_r(3, 1'b0, '0, 1'b0);
      mid();
      chk("t4_r3_data", 32'(o_data), 32'h53);
      chk("t4_r3_owner", 32'(o_owner), 32'd3);
      cyc();

      // 5: owner pauses mid-packet; others stay blocked, output drains
      reset_dut();
      acc = 1'b1;
      set_r(0, 1'b1, 8'h60, 1'b0);
      mid();
      chk("t5_start", 32'(acc_v), 32'b0001);
      cyc();
      set_r(0, 1'b0, '0, 1'b0);
      set_r(1, 1'b1, 8'h71, 1'b1);
      set_r(2, 1'b1, 8'h72, 1'b1);
      mid();
      chk("t5_gap1_acc", 32'(acc_v), 32'd0);
      chk("t5_gap1_oreq", 32'(o_req), 32'd1);
      chk("t5_gap1_data", 32'(o_data), 32'h60);
      cyc();
      mid();
      chk("t5_gap2_acc", 32'(acc_v), 32'd0);
      chk("t5_gap2_oreq", 32'(o_req), 32'd0);
      cyc();
      set_r(0, 1'b1, 8'h61, 1'b1);
      mid();
      chk("t5_resume", 32'(acc_v), 32'b0001);
      cyc();
      set_r(0, 1'b0, '0, 1'b0);
      mid();
      chk("t5_next", 32'(acc_v), 32'b0010);
      chk("t5_tail_data", 32'(o_data), 32'h61);
      cyc();

      // 6: reset mid-packet abandons the lock
      reset_dut();
      acc = 1'b1;
      set_r(1, 1'b1, 8'h81, 1'b0);
      mid();
      chk("t6_start", 32'(acc_v), 32'b0010);
      cyc();
      set_r(1, 1'b0, '0, 1'b0);
      acc = 1'b0;
      chk("t6_pre_oreq", 32'(o_req), 32'd1);
      #1 nrst = 1'b0;
      #1;
      chk("t6_rst_oreq", 32'(o_req), 32'd0);
      chk("t6_rst_odata", 32'(o_data), 32'd0);
      mid();
      #1 nrst = 1'b1;
      set_r(2, 1'b1, 8'h82, 1'b1);
      acc = 1'b1;
      #1 chk("t6_req2", 32'(acc_v), 32'b0100);
      cyc();
      set_r(2, 1'b0, '0, 1'b0);
      mid();
      chk("t6_r2_data", 32'(o_data), 32'h82);
      chk("t6_r2_owner", 32'(o_owner), 32'd2);
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/arb_out_4_rr_pkt.md
Name: arb_out_4_rr_pkt

Overview:
Four-requester round-robin output arbiter with packet locking and a one-entry registered output stage. It shares one downstream req/acc channel between four upstream sources that send multi-beat packets delimited by a last flag. Once a requester wins, it keeps the channel until its last beat is accepted, so packets are never interleaved. It sits between local packet sources and a shared output link, and replaces 2-way beat-level arbitration where packets must stay contiguous.

Parameters:
p_width, 8, data bits per beat.

Ports:
i_clk  input  1  clock, rising edge
i_nrst  input  1  asynchronous active-low reset
i_req0..i_req3  input  1 each  requester N has a beat valid
i_data0..i_data3  input  p_width each  beat payload from requester N
i_last0..i_last3  input  1 each  beat is final beat of packet
o_acc0..o_acc3  output  1 each  beat from requester N taken this cycle (combinational)
o_req  output  1  registered beat valid to downstream
o_data  output  p_width  registered payload
o_last  output  1  registered last flag
o_owner  output  2  index of requester whose beat is in the output register
i_acc  input  1  downstream takes o_data this cycle

Behaviour:
- Reset (async, i_nrst=0): o_req=0, o_data=0, o_last=0, o_owner=0, rr pointer=3 (requester 0 has first priority), lock=0, lock_id=0. o_accN=0 while in reset.
- Downstream handshake: o_req/o_data/o_last/o_owner are held stable while o_req=1 and i_acc=0. A beat transfers on i_acc & o_req. i_acc with o_req=0 is ignored.
- Upstream handshake: the requester holds i_reqN/data/last until o_accN=1. Beats transfer on i_reqN & o_accN.
- Load enable: ld = ~o_req | i_acc. The output register reloads in the same cycle it drains, giving full throughput of 1 beat/cycle.
- State IDLE (lock=0): candidates are all asserted i_reqN. The winner is the first asserted index scanning rr+1, rr+2, rr+3, rr (mod 4). If ld=1 and any request is present: o_acc[winner]=1, the register loads that winner's data/last, o_owner=winner.
  - If the winner's last=1: the packet ends. rr becomes the winner, and the state stays IDLE.
  - If last=0: go to LOCK with lock_id=winner. rr is unchanged.
- State LOCK: only requester lock_id is eligible; the others are ignored even if asserted. If ld & i_req[lock_id]: accept and load the beat. If that beat has last=1: rr becomes lock_id and the state returns to IDLE. While locked, requests from the other requesters do not advance rr.
- No request or ld=0: o_accN=0 and state/rr are unchanged. If i_acc=1 and nothing is loaded, o_req goes to 0.
- At most one o_accN is high in any cycle. o_accN never asserts without the matching i_reqN.
- Latency: a beat accepted in cycle t appears on o_req in cycle t+1.
- Reset mid-packet: all state clears and the partially sent packet is abandoned. Upstream must restart the packet after reset.
- Arithmetic: rr and lock_id are 2-bit. Index arithmetic wraps modulo 4 by natural overflow.

Decomposition:
- Package arb_pkg: localparam for requester count (4), index width (2), and state encodings IDLE=1'b0, LOCK=1'b1.
- One sub-module, rr_pick_4: combinational 4-bit request plus 2-bit pointer in, one-hot grant and 2-bit index out, rotating priority starting at pointer+1. Verify it standalone.
- The top level holds the lock FSM, pointer and output register.

Test Plan:
1. Reset, then i_req0=1, data=0x11, last=1, i_acc=1 -> o_acc0=1 in cycle 0; o_req=1, o_data=0x11, o_owner=0 in cycle 1; rr=0.
2. All four requesters assert single-beat packets continuously with i_acc=1 -> grant order 0,1,2,3,0,...; one beat per cycle, no bubbles.
3. Req1 sends a 3-beat packet (last on beat 3) while req2 is held high -> o_acc1 on three consecutive cycles, o_acc2 stays 0 until the cycle after the req1 last beat is accepted, then req2 wins.
4. Output full with i_acc=0 for 4 cycles while req3 is pending -> o_data stays stable, o_acc3=0 throughout. o_acc3=1 in the first cycle i_acc=1.
5. Locked on req0 with last=0, req0 deasserts for 2 cycles while req1/req2 are high -> no o_acc asserts, o_req drops after drain. Req0 resumes and completes, then req1 wins.
6. Assert i_nrst=0 mid-packet with o_req=1 -> o_req=0 and o_data=0 immediately. After release, req2 alone wins with no lock held.
